segre_dcache_controller: RTL
============================

// Module: segre_dcache_controller
// PURPOSE
// - Sequencing FSM and tag store for the direct-mapped, write-back L1 data cache data array.
// - Accepts one core load/store at a time and drives the data array's rd/wr/mem_wr strobes.
// - On a miss, writes back the dirty victim lane, refills the lane from memory, then replays the access.
// - Sits between the core LSU and the memory interface; the data array is a sibling instance.
// PARAMETERS
// - NUM_LANES       4   lanes (sets) in the data array; power of 2
// - BYTES_PER_LANE  16  bytes per lane; power of 2, >= WORD_SIZE/8
// - WORD_SIZE       32  core word and address width (from segre_pkg)
// - Derived: OFS=$clog2(BYTES_PER_LANE), IDX=$clog2(NUM_LANES), TAG=WORD_SIZE-OFS-IDX,
//   LANE_SIZE=8*BYTES_PER_LANE
// PORTS
// - clk_i             in   1          clock
// - rst_i             in   1          synchronous, active-high reset
// - req_valid_i       in   1          core request valid
// - req_ready_o       out  1          controller can accept (high only in IDLE)
// - req_we_i          in   1          1=store, 0=load
// - req_addr_i        in   WORD_SIZE  byte address; bits [1:0] ignored (word aligned)
// - req_wdata_i       in   WORD_SIZE  store data
// - rsp_valid_o       out  1          one-cycle pulse: access complete
// - rsp_rdata_o       out  WORD_SIZE  load data (0 for stores)
// - dc_rd_data_o      out  1          data array word read strobe
// - dc_wr_data_o      out  1          data array word write strobe
// - dc_mem_wr_data_o  out  1          data array lane fill strobe
// - dc_addr_o         out  WORD_SIZE  data array address (latched request address)
// - dc_wdata_o        out  WORD_SIZE  data array word write data
// - dc_mem_data_o     out  LANE_SIZE  data array fill data (= mem_rdata_i)
// - dc_rdata_i        in   WORD_SIZE  data array word read data, valid 1 cycle after dc_rd_data_o
// - dc_lane_i         in   LANE_SIZE  data array full-lane read of index dc_addr_o (combinational)
// - mem_req_valid_o   out  1          memory request valid
// - mem_req_we_o      out  1          1=lane writeback, 0=lane fetch
// - mem_addr_o        out  WORD_SIZE  lane-aligned address (low OFS bits zero)
// - mem_wdata_o       out  LANE_SIZE  writeback lane data
// - mem_ready_i       in   1          memory accepts request this cycle
// - mem_rsp_valid_i   in   1          fetch data valid
// - mem_rdata_i       in   LANE_SIZE  fetched lane
// BEHAVIOUR
// - Reset: state=IDLE; valid[], dirty[], tags cleared; all outputs 0 except req_ready_o=1 from the next cycle.
// - Tag store: per lane valid, dirty, tag[TAG-1:0]; index=addr[OFS+IDX-1:OFS].
// - States: IDLE, LOOKUP, RESPOND, WRITEBACK, FETCH, FILL_WAIT.
// - IDLE: req_ready_o=1; on req_valid_i latch addr/we/wdata, clear replay flag -> LOOKUP.
// - LOOKUP: hit = valid[idx] && tag[idx]==addr tag.
//   - load hit: dc_rd_data_o=1 -> RESPOND; store hit: dc_wr_data_o=1, dirty[idx]<=1 -> RESPOND.
//   - miss, valid&dirty victim -> WRITEBACK; otherwise -> FETCH.
// - RESPOND: rsp_valid_o=1 for one cycle, rsp_rdata_o=dc_rdata_i (load) or 0 -> IDLE.
// - Hit latency: accept at cycle N, rsp_valid_o at cycle N+2; back-to-back hits every 3 cycles.
// - WRITEBACK: mem_req_valid_o=1, we=1, addr={victim tag,idx,0}, wdata=dc_lane_i; held stable
//   until mem_ready_i; on handshake dirty[idx]<=0 -> FETCH.
// - FETCH: mem_req_valid_o=1, we=0, addr={req tag,idx,0}; on mem_ready_i -> FILL_WAIT.
// - FILL_WAIT: on mem_rsp_valid_i: dc_mem_wr_data_o=1, tag<=req tag, valid<=1, dirty<=0,
//   replay<=1 -> LOOKUP (replay always hits).
// - mem_rsp_valid_i outside FILL_WAIT is ignored; req_valid_i outside IDLE is ignored.
// - Strobes are mutually exclusive; at most one asserted per cycle.
// - Reset mid-operation: return to IDLE next cycle, mem_req_valid_o drops, pending access and
//   in-flight fetch data are discarded, all lanes invalidated (dirty data lost by design).
// CONFIGURATION
// - SEGRE_DCACHE_STATS_EN defined: adds outputs hit_cnt_o, miss_cnt_o (32 bit each).
//   - hit_cnt_o: +1 per LOOKUP hit with replay=0; miss_cnt_o: +1 per LOOKUP miss.
//   - Saturate at 32'hFFFF_FFFF; cleared by rst_i.
// - Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Reset, load 0x100 -> miss: FETCH addr 0x100; fill; rsp_valid_o 1 cycle after replay hit; rdata = fill word.
// - Load 0x104 after above -> hit; rsp_valid_o exactly 2 cycles after accept; no mem_req_valid_o.
// - Store 0xDEADBEEF @0x100, load 0x140 (same idx) -> WRITEBACK addr 0x100 we=1 before FETCH 0x140.
// - mem_ready_i low 5 cycles during WRITEBACK -> mem_addr_o/mem_wdata_o stable; no FETCH early.
// - rst_i in FILL_WAIT, then mem_rsp_valid_i -> ignored; next load 0x100 misses again.
// - STATS_EN: 1 miss + 3 hits -> miss_cnt_o=1, hit_cnt_o=3 (replay not counted).

Source files
------------

// File: rtl/segre_dcache_controller.sv
// Sequencing FSM and tag store for the direct-mapped, write-back L1 data cache.
// Define SEGRE_DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module segre_dcache_controller #(
    parameter int NUM_LANES      = 4,
    parameter int BYTES_PER_LANE = 16,
    parameter int WORD_SIZE      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [WORD_SIZE-1:0]          req_addr_i,
    input  logic [WORD_SIZE-1:0]          req_wdata_i,
    output logic                          rsp_valid_o,
    output logic [WORD_SIZE-1:0]          rsp_rdata_o,
    output logic                          dc_rd_data_o,
    output logic                          dc_wr_data_o,
    output logic                          dc_mem_wr_data_o,
    output logic [WORD_SIZE-1:0]          dc_addr_o,
    output logic [WORD_SIZE-1:0]          dc_wdata_o,
    output logic [8*BYTES_PER_LANE-1:0]   dc_mem_data_o,
    input  logic [WORD_SIZE-1:0]          dc_rdata_i,
    input  logic [8*BYTES_PER_LANE-1:0]   dc_lane_i,
    output logic                          mem_req_valid_o,
    output logic                          mem_req_we_o,
    output logic [WORD_SIZE-1:0]          mem_addr_o,
    output logic [8*BYTES_PER_LANE-1:0]   mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic                          mem_rsp_valid_i,
    input  logic [8*BYTES_PER_LANE-1:0]   mem_rdata_i
`ifdef SEGRE_DCACHE_STATS_EN
    ,
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o
`endif
);

    localparam int OFS = $clog2(BYTES_PER_LANE);
    localparam int IDX = $clog2(NUM_LANES);
    localparam int TAG = WORD_SIZE - OFS - IDX;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] RESPOND   = 3'd2;
    localparam logic [2:0] WRITEBACK = 3'd3;
    localparam logic [2:0] FETCH     = 3'd4;
    localparam logic [2:0] FILL_WAIT = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, wdata_q;
    logic                 we_q;
    logic [NUM_LANES-1:0] valid_q, dirty_q;
    logic [TAG-1:0]       tag_q [NUM_LANES];

    logic [IDX-1:0]       idx;
    logic [TAG-1:0]       req_tag;
    logic                 hit;

    assign idx     = addr_q[OFS+IDX-1:OFS];
    assign req_tag = addr_q[WORD_SIZE-1:OFS+IDX];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid_i) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)                              state_d = RESPOND;
                else if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
                else                                  state_d = FETCH;
            end
            RESPOND:   state_d = IDLE;
            WRITEBACK: if (mem_ready_i) state_d = FETCH;
            FETCH:     if (mem_ready_i) state_d = FILL_WAIT;
            FILL_WAIT: if (mem_rsp_valid_i) state_d = LOOKUP;
            default:   state_d = IDLE;
        endcase
    end

    assign req_ready_o      = (state_q == IDLE);
    assign dc_rd_data_o     = (state_q == LOOKUP) && hit && !we_q;
    assign dc_wr_data_o     = (state_q == LOOKUP) && hit && we_q;
    assign dc_mem_wr_data_o = (state_q == FILL_WAIT) && mem_rsp_valid_i;
    assign dc_addr_o        = addr_q;
    assign dc_wdata_o       = wdata_q;
    assign dc_mem_data_o    = mem_rdata_i;
    assign rsp_valid_o      = (state_q == RESPOND);
    assign rsp_rdata_o      = (state_q == RESPOND && !we_q) ? dc_rdata_i : '0;
    assign mem_req_valid_o  = (state_q == WRITEBACK) || (state_q == FETCH);
    assign mem_req_we_o     = (state_q == WRITEBACK);
    assign mem_wdata_o      = (state_q == WRITEBACK) ? dc_lane_i : '0;

    // Writeback targets the victim's line, fetch targets the requested line.
    always_comb begin
        mem_addr_o = '0;
        if (state_q == WRITEBACK)
            mem_addr_o = {tag_q[idx], idx, {OFS{1'b0}}};
        else if (state_q == FETCH)
            mem_addr_o = {req_tag, idx, {OFS{1'b0}}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        we_q    <= req_we_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                LOOKUP:    if (hit && we_q) dirty_q[idx] <= 1'b1;
                WRITEBACK: if (mem_ready_i) dirty_q[idx] <= 1'b0;
                FILL_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        tag_q[idx]   <= req_tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEGRE_DCACHE_STATS_EN
    // The replay flag keeps the post-fill lookup from being counted as a hit.
    logic replay_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            replay_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i)
                replay_q <= 1'b0;
            else if (state_q == FILL_WAIT && mem_rsp_valid_i)
                replay_q <= 1'b1;
            if (state_q == LOOKUP) begin
                if (!hit) begin
                    if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
                end else if (!replay_q && hit_cnt_o != '1) begin
                    hit_cnt_o <= hit_cnt_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule
